amo_rmw_sequencer: RTL and testbench



---
 rtl/amo_pkg.sv | 34 +++
 rtl/amo_alu.sv | 54 +++++
 rtl/amo_rmw_sequencer.sv | 174 +++++++++++++++++
 tb/tb_amo_rmw_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amo_pkg
// Description : Shared definitions for the AMO read-modify-write sequencer:
//               AMO function codes, FSM state encoding and a helper that
//               tells whether a function code uses a signed comparison.
// Revision    : 1.0 - initial release
// ============================================================================
package amo_pkg;

  // AMO function codes; every code not listed here is a SWAP
  localparam logic [4:0] AMO_ADD  = 5'd8;
  localparam logic [4:0] AMO_XOR  = 5'd9;
  localparam logic [4:0] AMO_OR   = 5'd10;
  localparam logic [4:0] AMO_AND  = 5'd11;
  localparam logic [4:0] AMO_MIN  = 5'd12;
  localparam logic [4:0] AMO_MAX  = 5'd13;
  localparam logic [4:0] AMO_MINU = 5'd14;
  localparam logic [4:0] AMO_MAXU = 5'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_RESP    = 3'd4
  } amo_state_e;

  function automatic logic is_signed_cmp(input logic [4:0] fn);
    return (fn == AMO_MIN) || (fn == AMO_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/amo_alu.sv
`default_nettype none
// ============================================================================
// Module      : amo_alu
// Description : Purely combinational 32-bit AMO ALU.
//               a_i      : old memory word
//               b_i      : store operand
//               fn_i     : AMO function code
//               result_o : new memory word
//               MIN/MAX ties return the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module amo_alu
  import amo_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  fn_i,
  output logic [31:0] result_o
);

  logic w_signed;
  logic w_b_lt_a;
  logic w_a_lt_b;

  // For signed compares with differing signs, the operand with bit31 set
  // is the smaller one; otherwise a plain unsigned compare is exact.
  always_comb begin
    w_signed = is_signed_cmp(fn_i) && (a_i[31] != b_i[31]);
    if (w_signed) begin
      w_b_lt_a = b_i[31];
      w_a_lt_b = a_i[31];
    end else begin
      w_b_lt_a = (b_i < a_i);
      w_a_lt_b = (a_i < b_i);
    end
  end

  always_comb begin
    result_o = b_i;
    case (fn_i)
      AMO_ADD:  result_o = a_i + b_i;
      AMO_XOR:  result_o = a_i ^ b_i;
      AMO_OR:   result_o = a_i | b_i;
      AMO_AND:  result_o = a_i & b_i;
      AMO_MIN,
      AMO_MINU: result_o = w_b_lt_a ? b_i : a_i;
      AMO_MAX,
      AMO_MAXU: result_o = w_a_lt_b ? b_i : a_i;
      default:  result_o = b_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/amo_rmw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : amo_rmw_sequencer
// Description : Read-modify-write controller for 32-bit atomic memory ops.
//               Accepts one AMO request, reads the old word, computes the new
//               word with amo_alu, writes it back and returns the old word.
//               The memory port is locked from read request to write request.
//   Ports:
//     clock/reset          : clock, synchronous active-high reset
//     req_*                : AMO request (valid/ready, addr, data, fn)
//     mem_rd_*             : read request channel (valid/ready, addr)
//     mem_rdata*           : read data return pulse with error flag
//     mem_wr_*             : write request channel (valid/ready, addr, data)
//     resp_*               : response (valid/ready, old word, error)
//     mem_lock, busy       : port reservation and activity status
// Revision    : 1.0 - initial release
// ============================================================================
module amo_rmw_sequencer
  import amo_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [4:0]        req_fn,
  output logic              mem_lock,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_err,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("amo_rmw_sequencer: DATA_W must be 32");
  end

  amo_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [4:0]        fn_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] new_q;
  logic              resp_err_q;
  logic              req_ready_q;
  logic              rd_valid_q;
  logic              wr_valid_q;
  logic              resp_valid_q;
  logic              lock_q;
  logic              busy_q;
  logic [DATA_W-1:0] alu_new_d;

  // Operand a is taken straight from the read return so the new word can be
  // registered in the same cycle the old word arrives.
  amo_alu u_alu (
    .a_i      (mem_rdata),
    .b_i      (data_q),
    .fn_i     (fn_q),
    .result_o (alu_new_d)
  );

  // Outputs are registered and updated together with the state so each
  // valid is held with a constant payload until its ready is seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      fn_q         <= '0;
      old_q        <= '0;
      new_q        <= '0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            data_q      <= req_data;
            fn_q        <= req_fn;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rd_valid_q  <= 1'b1;
            lock_q      <= 1'b1;
            state_q     <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (mem_rd_ready) begin
            rd_valid_q <= 1'b0;
            state_q    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rdata_valid) begin
            old_q <= mem_rdata;
            if (mem_rdata_err) begin
              // Abort: release the port and respond without writing
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              lock_q       <= 1'b0;
              state_q      <= S_RESP;
            end else begin
              new_q      <= alu_new_d;
              wr_valid_q <= 1'b1;
              state_q    <= S_WR_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (mem_wr_ready) begin
            wr_valid_q   <= 1'b0;
            lock_q       <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          rd_valid_q   <= 1'b0;
          wr_valid_q   <= 1'b0;
          resp_valid_q <= 1'b0;
          lock_q       <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign mem_lock     = lock_q;
  assign mem_rd_valid = rd_valid_q;
  assign mem_rd_addr  = addr_q;
  assign mem_wr_valid = wr_valid_q;
  assign mem_wr_addr  = addr_q;
  assign mem_wr_data  = new_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = old_q;
  assign resp_err     = resp_err_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_amo_rmw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_amo_rmw_sequencer
// Description : Self-checking bench for amo_rmw_sequencer. A transaction-level
//               model follows the handshakes and predicts every output each
//               cycle; directed cases pin literal results, then a randomized
//               phase exercises all function codes, stalls and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amo_rmw_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [4:0]  req_fn;
  logic        mem_lock;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        mem_rdata_err;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  always #5 clock = ~clock;

  amo_rmw_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_fn          (req_fn),
    .mem_lock        (mem_lock),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_ready    (mem_rd_ready),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .mem_rdata_err   (mem_rdata_err),
    .mem_wr_valid    (mem_wr_valid),
    .mem_wr_ready    (mem_wr_ready),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .busy            (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: phase 0 idle, 1 read requested, 2 awaiting data,
  // 3 write requested, 4 responding.
  int          m_ph = 0;
  logic [31:0] m_addr, m_data, m_old, m_new;
  logic [4:0]  m_fn;
  logic        m_err = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  logic [31:0] last_wr_addr, last_wr_data, last_resp_data;
  logic        last_resp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] amo_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] fn);
    case (fn)
      5'd8:    return a + b;
      5'd9:    return a ^ b;
      5'd10:   return a | b;
      5'd11:   return a & b;
      5'd12:   return ($signed(b) < $signed(a)) ? b : a;
      5'd13:   return ($signed(b) > $signed(a)) ? b : a;
      5'd14:   return (b < a) ? b : a;
      5'd15:   return (b > a) ? b : a;
      default: return b;
    endcase
  endfunction

  // Compare current outputs with the model, then advance the model by the
  // handshakes that the coming rising edge will complete.
  task automatic cycle_check();
    chk("req_ready",  req_ready,    m_ph == 0);
    chk("busy",       busy,         m_ph != 0);
    chk("mem_lock",   mem_lock,     m_ph >= 1 && m_ph <= 3);
    chk("rd_valid",   mem_rd_valid, m_ph == 1);
    chk("wr_valid",   mem_wr_valid, m_ph == 3);
    chk("resp_valid", resp_valid,   m_ph == 4);
    if (m_ph == 1) chk("rd_addr", mem_rd_addr, m_addr);
    if (m_ph == 3) begin
      chk("wr_addr", mem_wr_addr, m_addr);
      chk("wr_data", mem_wr_data, m_new);
    end
    if (m_ph == 4) begin
      chk("resp_data", resp_data, m_old);
      chk("resp_err",  resp_err,  m_err);
    end else begin
      chk("resp_err_idle", resp_err, 1'b0);
    end
    if (mem_wr_valid && mem_wr_ready) begin
      wr_cnt++;
      last_wr_addr = mem_wr_addr;
      last_wr_data = mem_wr_data;
    end
    if (mem_rd_valid && mem_rd_ready) rd_cnt++;
    if (resp_valid && resp_ready) begin
      resp_cnt++;
      last_resp_data = resp_data;
      last_resp_err  = resp_err;
    end
    if (reset) begin
      m_ph  = 0;
      m_err = 1'b0;
    end else begin
      case (m_ph)
        0: if (req_valid) begin
             m_addr = req_addr; m_data = req_data; m_fn = req_fn; m_ph = 1;
           end
        1: if (mem_rd_ready) m_ph = 2;
        2: if (mem_rdata_valid) begin
             m_old = mem_rdata;
             if (mem_rdata_err) begin
               m_err = 1'b1; m_ph = 4;
             end else begin
               m_new = amo_ref(mem_rdata, m_data, m_fn); m_ph = 3;
             end
           end
        3: if (mem_wr_ready) m_ph = 4;
        4: if (resp_ready) begin
             m_err = 1'b0; m_ph = 0;
           end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cycle_check();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // One complete AMO with optional stalls. Returns the number of edges from
  // the accepting edge to the first cycle showing resp_valid (-1 on timeout).
  task automatic do_op(input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] fn, input logic [31:0] old, input logic err,
                       input int rs, input int ws, input int ps, input logic stray,
                       output int lat);
    int t0;
    if (stray) begin
      mem_rdata_valid = 1'b1; mem_rdata = 32'h1234_5678; tick();
      mem_rdata_valid = 1'b0;
    end
    req_valid = 1'b1; req_addr = addr; req_data = data; req_fn = fn;
    tick();
    t0 = cyc;
    req_valid = 1'b0; req_addr = ~addr; req_data = ~data; req_fn = 5'd3;
    for (int i = 0; i < rs; i++) begin
      mem_rdata_valid = stray; mem_rdata = 32'hBAD0_BAD0; tick();
    end
    mem_rdata_valid = stray; mem_rdata = 32'hBAD0_BAD0;
    mem_rd_ready = 1'b1; tick();
    mem_rd_ready = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = old; mem_rdata_err = err; tick();
    mem_rdata_valid = 1'b0; mem_rdata_err = 1'b0; mem_rdata = 32'h0;
    if (!err) begin
      for (int i = 0; i < ws; i++) tick();
      mem_wr_ready = 1'b1; tick();
      mem_wr_ready = 1'b0;
    end
    for (int i = 0; i < 10 && !resp_valid; i++) tick();
    lat = resp_valid ? (cyc - t0) : -1;
    chk("resp_seen", resp_valid, 1'b1);
    for (int i = 0; i < ps; i++) tick();
    resp_ready = 1'b1; tick();
    resp_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, w0, r0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_fn = '0;
    mem_rd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0; mem_rdata_err = 1'b0;
    mem_wr_ready = 1'b0; resp_ready = 1'b0;
    @(posedge clock); #1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_req_ready", req_ready,   1'b1);
    chk("rst_busy",      busy,        1'b0);
    chk("rst_lock",      mem_lock,    1'b0);
    chk("rst_rd_addr",   mem_rd_addr, 32'h0);
    chk("rst_wr_data",   mem_wr_data, 32'h0);
    chk("rst_resp_data", resp_data,   32'h0);
    chk("rst_resp_err",  resp_err,    1'b0);

    // ADD with wrap, zero-wait port; RESP appears in the 4th cycle,
    // i.e. three edges after the accepting edge.
    do_op(32'h100, 32'h1, 5'd8, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 1'b0, lat);
    chk("add_latency",   lat,            3);
    chk("add_wr_data",   last_wr_data,   32'h0000_0000);
    chk("add_wr_addr",   last_wr_addr,   32'h100);
    chk("add_resp_data", last_resp_data, 32'hFFFF_FFFF);
    chk("add_resp_err",  last_resp_err,  1'b0);

    // Signed vs unsigned min/max
    do_op(32'h40, 32'h1, 5'd12, 32'h8000_0000, 1'b0, 0, 0, 0, 1'b0, lat);
    chk("min_signed",   last_wr_data, 32'h8000_0000);
    do_op(32'h40, 32'h1, 5'd14, 32'h8000_0000, 1'b0, 0, 0, 0, 1'b0, lat);
    chk("min_unsigned", last_wr_data, 32'h0000_0001);
    do_op(32'h40, 32'h1, 5'd15, 32'h8000_0000, 1'b0, 0, 0, 0, 1'b0, lat);
    chk("max_unsigned", last_wr_data, 32'h8000_0000);
    do_op(32'h40, 32'h1, 5'd13, 32'h8000_0000, 1'b0, 0, 0, 0, 1'b0, lat);
    chk("max_signed",   last_wr_data, 32'h0000_0001);

    // Swap with backpressure on every channel
    w0 = wr_cnt; r0 = rd_cnt;
    do_op(32'h2C0, 32'hDEAD_BEEF, 5'd0, 32'h0BAD_F00D, 1'b0, 3, 2, 2, 1'b0, lat);
    chk("swap_wr_data", last_wr_data,  32'hDEAD_BEEF);
    chk("swap_wr_addr", last_wr_addr,  32'h2C0);
    chk("swap_resp",    last_resp_data, 32'h0BAD_F00D);
    chk("swap_one_wr",  wr_cnt - w0,   1);
    chk("swap_one_rd",  rd_cnt - r0,   1);

    // Read error: no write, error response, error cleared afterwards
    w0 = wr_cnt;
    do_op(32'h80, 32'h5, 5'd8, 32'h55AA_55AA, 1'b1, 0, 0, 0, 1'b0, lat);
    chk("err_no_write",  wr_cnt - w0,    0);
    chk("err_resp_data", last_resp_data, 32'h55AA_55AA);
    chk("err_resp_err",  last_resp_err,  1'b1);
    chk("err_cleared",   resp_err,       1'b0);
    chk("err_idle",      req_ready,      1'b1);

    // Reset while a write is pending
    req_valid = 1'b1; req_addr = 32'h200; req_data = 32'h7; req_fn = 5'd8; tick();
    req_valid = 1'b0;
    mem_rd_ready = 1'b1; tick(); mem_rd_ready = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 32'hA; tick(); mem_rdata_valid = 1'b0;
    chk("midop_in_wr", mem_wr_valid, 1'b1);
    w0 = wr_cnt;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_wr_valid",   mem_wr_valid, 1'b0);
    chk("midrst_rd_valid",   mem_rd_valid, 1'b0);
    chk("midrst_resp_valid", resp_valid,   1'b0);
    chk("midrst_lock",       mem_lock,     1'b0);
    chk("midrst_req_ready",  req_ready,    1'b1);
    mem_wr_ready = 1'b1; tick(); tick(); mem_wr_ready = 1'b0;
    chk("midrst_no_write", wr_cnt - w0, 0);
    do_op(32'h300, 32'h3, 5'd11, 32'h5, 1'b0, 0, 0, 0, 1'b0, lat);
    chk("and_after_rst", last_wr_data, 32'h0000_0001);

    // Stray read-data pulses in IDLE and RD_REQ must be ignored
    do_op(32'h44, 32'hFF00_FF00, 5'd9, 32'h0F0F_0F0F, 1'b0, 2, 0, 0, 1'b1, lat);
    chk("stray_wr_data", last_wr_data,   32'hF00F_F00F);
    chk("stray_resp",    last_resp_data, 32'h0F0F_0F0F);

    // Randomized traffic checked cycle by cycle against the model
    w0 = resp_cnt;
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(0, 399) == 0);
      req_valid       = ($urandom_range(0, 2) == 0);
      req_addr        = $urandom;
      req_data        = rnd_word();
      req_fn          = 5'($urandom_range(0, 19));
      mem_rd_ready    = $urandom_range(0, 1);
      mem_wr_ready    = $urandom_range(0, 1);
      resp_ready      = $urandom_range(0, 1);
      mem_rdata       = rnd_word();
      mem_rdata_err   = ($urandom_range(0, 7) == 0);
      mem_rdata_valid = (m_ph == 2) ? ($urandom_range(0, 2) == 0)
                                    : ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b0; req_valid = 1'b0; mem_rdata_valid = 1'b0;
    chk("rand_progress", (resp_cnt - w0) > 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
